config_sequencer: RTL

CONFIG_SEQUENCER -- requirements
Module: config_sequencer

---
 rtl/config_pkg.sv | 20 ++
 rtl/config_fifo.sv | 37 +++
 rtl/config_sequencer.sv | 106 ++++++++++
 3 files changed

// File: rtl/config_pkg.sv
// config_pkg: shared types and constants for the configuration sequencer.
// Holds target-type codes, the idle bus address, the broadcast tile id,
// the sequencer state enum and the buffered command struct.
package config_pkg;
  localparam logic [15:0] CONFIG_SB  = 16'd7;
  localparam logic [15:0] CONFIG_CB0 = 16'd6;
  localparam logic [15:0] CONFIG_CB1 = 16'd5;
  localparam logic [15:0] CONFIG_CLB = 16'd4;
  localparam logic [31:0] IDLE_ADDR  = 32'h0000_0000;
  localparam logic [15:0] BCAST_ID   = 16'hFFFF;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BCAST, S_FINISH} state_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } cmd_t;
  function automatic logic is_bcast(cmd_t c);
    return c.addr[15:0] == BCAST_ID;
  endfunction
endpackage

// File: rtl/config_fifo.sv
// config_fifo: synchronous FIFO with full/empty flags; a push while full
// succeeds when a pop happens in the same cycle.
// Ports: clk, reset (sync, active-low), i_push, i_pop, i_data,
//        o_data (head, valid when !o_empty), o_full, o_empty.
module config_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0] r_wp, r_rp;
  logic w_wr, w_rd;
  assign o_empty = r_wp == r_rp;
  assign o_full  = r_wp == {~r_rp[AW], r_rp[AW-1:0]};
  assign w_rd    = i_pop && !o_empty;
  assign w_wr    = i_push && (!o_full || w_rd);
  assign o_data  = r_mem[r_rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      r_wp <= w_wr ? r_wp + (AW+1)'(1) : r_wp;
      r_rp <= w_rd ? r_rp + (AW+1)'(1) : r_rp;
    end
  end
  always_ff @(posedge clk) if (w_wr) r_mem[r_wp[AW-1:0]] <= i_data;
endmodule

// File: rtl/config_sequencer.sv
// config_sequencer: buffers host config commands and issues them as one-cycle
// array writes, pulsing done after the last command of a bitstream.
// Optional feature macro: CONFIG_SEQUENCER_BROADCAST_EN (tile_id 16'hFFFF
// expands into NUM_TILES writes to tiles 0..NUM_TILES-1).
// Ports: clk, reset (sync, active-low); host side cmd_valid/cmd_ready/
//        cmd_addr/cmd_data/cmd_last; array side config_addr/config_data;
//        status busy, done, write_count.
module config_sequencer
  import config_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_TILES  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic        cmd_last,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] write_count
);
  state_t r_state, w_next, w_go;
  cmd_t r_hold, w_head, w_cmd_in;
  logic r_hv, w_full, w_empty, w_push, w_pop, w_end, w_wr;
  logic [15:0] r_wc;
  assign w_cmd_in    = {cmd_addr, cmd_data, cmd_last};
  assign cmd_ready   = reset && !w_full;
  assign w_push      = cmd_valid && cmd_ready;
  assign w_wr        = r_state inside {S_ISSUE, S_BCAST};
  assign busy        = r_state != S_IDLE || !w_empty || r_hv;
  assign write_count = r_wc;
  config_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(cmd_t))) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_cmd_in),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
`ifdef CONFIG_SEQUENCER_BROADCAST_EN
  logic [15:0] r_tile;
  assign w_end = r_state == S_ISSUE || (r_state == S_BCAST && r_tile == 16'(NUM_TILES - 1));
  assign w_go  = (r_hv ? is_bcast(r_hold) : is_bcast(w_head)) ? S_BCAST : S_ISSUE;
  always_ff @(posedge clk) begin
    if (!reset) r_tile <= '0;
    else r_tile <= w_pop ? '0 : (r_state == S_BCAST) ? r_tile + 16'd1 : r_tile;
  end
`else
  assign w_end = r_state == S_ISSUE;
  assign w_go  = S_ISSUE;
`endif
  // r_hv marks a command popped at the end of a write and waiting one IDLE
  // cycle in r_hold, which keeps the cadence at one write every two cycles.
  always_comb begin
    w_next      = r_state;
    w_pop       = 1'b0;
    done        = 1'b0;
    config_addr = IDLE_ADDR;
    config_data = '0;
    case (r_state)
      S_IDLE: begin
        w_pop  = !r_hv && !w_empty;
        w_next = (r_hv || !w_empty) ? w_go : S_IDLE;
      end
      S_ISSUE: begin
        config_addr = r_hold.addr;
        config_data = r_hold.data;
      end
`ifdef CONFIG_SEQUENCER_BROADCAST_EN
      S_BCAST: begin
        config_addr = {r_hold.addr[31:16], r_tile};
        config_data = r_hold.data;
      end
`endif
      S_FINISH: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_end) begin
      w_pop  = !r_hold.last && !w_empty;
      w_next = r_hold.last ? S_FINISH : S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_hold  <= '0;
      r_hv    <= 1'b0;
      r_wc    <= '0;
    end else begin
      r_state <= w_next;
      r_hv    <= w_end && w_pop;
      if (w_pop) r_hold <= w_head;
      r_wc    <= (r_state == S_FINISH) ? '0 : (w_wr && r_wc != 16'hFFFF) ? r_wc + 16'd1 : r_wc;
    end
  end
endmodule
